fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the MIPS core: owns the program counter, fetches one 32-bit instruction per turn from instruction memory over a req/ack handshake, and holds it stable for the decoder/datapath. It sits directly upstream of the main/ALU decoder, feeding op/funct via `instr`. It consumes that stage's `pcsrc` and `jump` results to select the next PC: sequential, branch target or jump target.

## Interface
- `RESET_PC`, default 32'h0000_0000; PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address, equal to `pc`; bits [1:0] always 0.
- `imem_ack`  in  1  memory returns data this cycle; valid only while `imem_req`=1.
- `imem_rdata`  in  32  instruction word, sampled when `imem_req & imem_ack`.
- `instr`  out  32  held instruction; [31:26]=op, [5:0]=funct to the decoder.
- `instr_valid`  out  1  `instr` is valid and stable.
- `instr_ready`  in  1  downstream has executed `instr`; `pcsrc`/`jump` are valid this cycle.
- `pcsrc`  in  1  take branch; sampled only on `instr_valid & instr_ready`.
- `jump`  in  1  take jump; sampled only on `instr_valid & instr_ready`.
- `pc`  out  32  address of the instruction being fetched or held.
- `pcplus4`  out  32  `pc + 4`, modulo 2^32.
- `fetch_count`, `stall_count`  out  32 each  present only with `FETCH_PERF_EN` (see Configuration).

## Operation
- States:
  - F_IDLE: `imem_req`=0, `instr_valid`=0.
  - F_FETCH: `imem_req`=1.
  - F_HOLD: `instr_valid`=1.
- Reset (any cycle, any state): state←F_IDLE, `pc`←RESET_PC, `instr`←0, `instr_valid`=0, `imem_req`=0; any outstanding request is abandoned.
- F_IDLE → F_FETCH unconditionally on the next cycle.
- F_FETCH:
  - Hold `imem_req`=1 and keep `imem_addr` constant until `imem_ack`.
  - On ack: `instr`←`imem_rdata`, go to F_HOLD.
  - No ack: stay in F_FETCH.
- F_HOLD:
  - `instr` and `pc` stay frozen until `instr_ready`.
  - On `instr_ready`: load the next PC and go to F_FETCH.
- Next-PC priority:
  1. `jump`: {pcplus4[31:28], instr[25:0], 2'b00}.
  2. `pcsrc`: pcplus4 + (sign-extended instr[15:0] << 2).
  3. Otherwise: pcplus4.
- `jump` and `pcsrc` both set: jump wins.
- All address arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0; a negative branch offset below 0 also wraps.
- `imem_ack` in F_IDLE or F_HOLD is ignored; `instr_ready` outside F_HOLD is ignored.
- Outputs are Moore (functions of registered state and registers only); the only combinational path is `instr_ready`/`pcsrc`/`jump` into the next-PC register input.

## Timing
- Zero-wait memory (ack in the same cycle as req): 2 cycles per instruction (F_FETCH, F_HOLD with ready).
- First `imem_req` occurs 1 cycle after reset deasserts (F_IDLE cycle).
- N-cycle memory latency adds N cycles in F_FETCH.
- A stall of M cycles (ready low) adds M cycles in F_HOLD.
- Next PC is visible on `pc`/`imem_addr` in the cycle after the `instr_ready` handshake.
- `instr_valid` drops in the cycle after the handshake and rises in the cycle after ack.

## Configuration
- `FETCH_PERF_EN` defined:
  - Adds `fetch_count` (increments on each `imem_req & imem_ack`).
  - Adds `stall_count` (increments each cycle in F_HOLD with `instr_ready`=0).
  - Both reset to 0, wrap at 2^32.
- Not defined: both ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_t` enum {F_IDLE, F_FETCH, F_HOLD}.
  - Field constants: OP_MSB=31, OP_LSB=26, IMM_W=16, JADDR_W=26.
  - Default RESET_PC.
- One sub-module `pc_next_sel`: combinational next-PC selection (pcplus4, branch target, jump target, priority mux).
- The FSM, PC register, instruction register and perf counters stay in `fetch_unit`.

## Test plan
- Reset, then zero-wait memory with ready always high: `imem_addr` sequence 0x0, 0x4, 0x8 on cycles 1, 3, 5 after reset release; `imem_req` low on cycle 0.
- Held instr 0x1000_FFFF (offset −1) at pc 0x100, `pcsrc`=1 on handshake → next `imem_addr`=0x100 (branch-to-self).
- Held instr 0x0800_0040 at pc 0x4000_0010, `jump`=1 and `pcsrc`=1 → next `imem_addr`=0x4000_0100 (jump priority).
- RESET_PC=32'hFFFF_FFFC, no branch → second fetch address 0x0000_0000.
- Ack delayed 3 cycles with `imem_rdata` changing before ack → `imem_addr` stable; `instr` equals the value at the ack cycle. Then `instr_ready` low for 4 cycles → `instr` frozen, `stall_count`=4 with `FETCH_PERF_EN`.
- Reset asserted in F_FETCH while a request is pending, with ack arriving during reset → ack ignored, `instr_valid`=0, `pc`=RESET_PC, refetch starts 1 cycle after reset release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and field constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_FETCH = 2'd1,
        F_HOLD  = 2'd2
    } fetch_state_t;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int IMM_W   = 16;
    localparam int JADDR_W = 26;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] sign_ext_imm(input logic [IMM_W-1:0] imm);
        return {{(32 - IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: sequential, branch target or jump target.
module pc_next_sel
    import fetch_pkg::*;
(
    input  logic [31:0]        pc_i,
    input  logic [JADDR_W-1:0] instr_index_i,
    input  logic               pcsrc_i,
    input  logic               jump_i,
    output logic [31:0]        pcplus4_o,
    output logic [31:0]        pc_next_o
);

    logic [31:0] imm_ext_s;
    logic [31:0] branch_tgt_s;
    logic [31:0] jump_tgt_s;

    assign pcplus4_o    = pc_i + 32'd4;
    assign imm_ext_s    = sign_ext_imm(instr_index_i[IMM_W-1:0]);
    assign branch_tgt_s = pcplus4_o + (imm_ext_s << 2);
    // Jumps stay inside the 256 MB region of the delay-slot address.
    assign jump_tgt_s   = {pcplus4_o[31:28], instr_index_i, 2'b00};

    // Priority select: jump over branch over sequential.
    always_comb begin
        pc_next_o = pcplus4_o;
        if (jump_i) begin
            pc_next_o = jump_tgt_s;
        end else if (pcsrc_i) begin
            pc_next_o = branch_tgt_s;
        end else begin
            pc_next_o = pcplus4_o;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// MIPS fetch stage: PC register, imem req/ack FSM and held instruction register.
// Optional performance counters are enabled with the FETCH_PERF_EN macro.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master imem,
    output logic [31:0]  instr,
    output logic         instr_valid,
    input  logic         instr_ready,
    input  logic         pcsrc,
    input  logic         jump,
    output logic [31:0]  pc,
    output logic [31:0]  pcplus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  fetch_count,
    output logic [31:0]  stall_count
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         imem_req_q, imem_req_d;
    logic         instr_valid_q, instr_valid_d;
    logic [31:0]  pc_next_s;
    logic [31:0]  pcplus4_s;
    logic         ack_s;
    logic         stall_s;

    assign ack_s   = imem_req_q & imem.imem_ack;
    assign stall_s = instr_valid_q & ~instr_ready;

    pc_next_sel u_pc_next_sel (
        .pc_i          (pc_q),
        .instr_index_i (instr_q[JADDR_W-1:0]),
        .pcsrc_i       (pcsrc),
        .jump_i        (jump),
        .pcplus4_o     (pcplus4_s),
        .pc_next_o     (pc_next_s)
    );

    // Next-state, PC and instruction register update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            F_IDLE: begin
                state_d = F_FETCH;
            end
            F_FETCH: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = F_HOLD;
                end else begin
                    state_d = F_FETCH;
                end
            end
            F_HOLD: begin
                if (instr_ready) begin
                    pc_d    = pc_next_s;
                    state_d = F_FETCH;
                end else begin
                    state_d = F_HOLD;
                end
            end
            default: begin
                state_d = F_IDLE;
            end
        endcase
        // Handshake outputs are registered copies of the next-state decode.
        imem_req_d    = (state_d == F_FETCH);
        instr_valid_d = (state_d == F_HOLD);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= F_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0000_0000;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem.imem_req  = imem_req_q;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = instr_valid_q;
    assign pc             = pc_q;
    assign pcplus4        = pcplus4_s;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Counter increments; both wrap naturally at 2^32.
    always_comb begin
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        if (ack_s) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end else begin
            fetch_count_d = fetch_count_q;
        end
        if (stall_s) begin
            stall_count_d = stall_count_q + 32'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= 32'h0000_0000;
            stall_count_q <= 32'h0000_0000;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`else
    logic unused_perf_s;
    assign unused_perf_s = ack_s ^ stall_s;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: fixed vector table, hand sequences and
// randomized transactions checked against a next-PC reference model.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        instr_ready, pcsrc, jump;
    logic [31:0] instr, pc, pcplus4;
    logic        instr_valid;
    logic [31:0] w_instr, w_pc, w_pp4, h_instr, h_pc, h_pp4;
    logic        w_valid, h_valid;

    fetch_unit_if imem_if();
    fetch_unit_if wrap_if();
    fetch_unit_if hi_if();

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, stall_count, w_fc, w_sc, h_fc, h_sc;
`endif

    fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .reset(reset), .imem(imem_if), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pcsrc(pcsrc), .jump(jump), .pc(pc), .pcplus4(pcplus4)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(reset), .imem(wrap_if), .instr(w_instr), .instr_valid(w_valid),
        .instr_ready(1'b1), .pcsrc(1'b0), .jump(1'b0), .pc(w_pc), .pcplus4(w_pp4)
`ifdef FETCH_PERF_EN
        , .fetch_count(w_fc), .stall_count(w_sc)
`endif
    );

    fetch_unit #(.RESET_PC(32'h4000_0010)) u_hi (
        .clk(clk), .reset(reset), .imem(hi_if), .instr(h_instr), .instr_valid(h_valid),
        .instr_ready(1'b1), .pcsrc(1'b1), .jump(1'b1), .pc(h_pc), .pcplus4(h_pp4)
`ifdef FETCH_PERF_EN
        , .fetch_count(h_fc), .stall_count(h_sc)
`endif
    );

    typedef struct {
        logic [31:0] rdata;
        int          dly;
        int          stl;
        logic        br;
        logic        jp;
        logic [31:0] nxt;
    } vec_t;

    vec_t        vecs [8];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch, exp_stall;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference next-PC computed from the architectural rules.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] word,
                                               input logic br, input logic jp);
        logic [31:0] seq;
        int          off;
        seq = cur + 32'd4;
        if (jp) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
        if (br) begin
            off = int'($signed(word[15:0])) * 4;
            return seq + 32'(off);
        end
        return seq;
    endfunction

    task automatic check_perf();
`ifdef FETCH_PERF_EN
        check("fetch_count", fetch_count, exp_fetch);
        check("stall_count", stall_count, exp_stall);
`endif
    endtask

    // Entered at a negedge with the DUT in F_FETCH at exp_pc.
    task automatic txn(input logic [31:0] word, input int dly, input int stl,
                       input logic br, input logic jp, input logic [31:0] nxt);
        for (int i = 0; i < dly; i++) begin
            check("wait_addr", imem_if.imem_addr, exp_pc);
            imem_if.imem_ack   = 1'b0;
            imem_if.imem_rdata = $urandom;
            instr_ready        = 1'($urandom_range(0, 1));
            @(posedge clk); @(negedge clk);
        end
        check("fetch_req", 32'(imem_if.imem_req), 32'd1);
        check("fetch_addr", imem_if.imem_addr, exp_pc);
        imem_if.imem_ack   = 1'b1;
        imem_if.imem_rdata = word;
        instr_ready        = 1'($urandom_range(0, 1));
        @(posedge clk); @(negedge clk);
        exp_fetch++;
        imem_if.imem_ack   = 1'b0;
        imem_if.imem_rdata = $urandom;
        check("hold_valid", 32'(instr_valid), 32'd1);
        check("hold_req", 32'(imem_if.imem_req), 32'd0);
        check("hold_instr", instr, word);
        check("hold_pcplus4", pcplus4, exp_pc + 32'd4);
        for (int i = 0; i < stl; i++) begin
            imem_if.imem_ack   = 1'($urandom_range(0, 1));
            imem_if.imem_rdata = $urandom;
            instr_ready        = 1'b0;
            pcsrc              = 1'($urandom_range(0, 1));
            jump               = 1'($urandom_range(0, 1));
            @(posedge clk); @(negedge clk);
            exp_stall++;
            check("stall_instr", instr, word);
            check("stall_pc", pc, exp_pc);
        end
        imem_if.imem_ack = 1'($urandom_range(0, 1));
        instr_ready      = 1'b1;
        pcsrc            = br;
        jump             = jp;
        @(posedge clk); @(negedge clk);
        instr_ready      = 1'b0;
        imem_if.imem_ack = 1'b0;
        pcsrc            = 1'b0;
        jump             = 1'b0;
        check("next_valid", 32'(instr_valid), 32'd0);
        check("next_addr", imem_if.imem_addr, nxt);
        check_perf();
        exp_pc = nxt;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; imem_if.imem_ack = 1'b0; instr_ready = 1'b0; pcsrc = 1'b0; jump = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_pc = 32'h0; exp_fetch = 32'h0; exp_stall = 32'h0;
        check("rst_req", 32'(imem_if.imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_pc", pc, 32'h0);
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{32'h0800_0040, 0, 0, 1'b0, 1'b1, 32'h0000_0100};
        vecs[1] = '{32'h1000_FFFF, 1, 0, 1'b1, 1'b0, 32'h0000_0100};
        vecs[2] = '{32'h1000_0003, 0, 2, 1'b1, 1'b0, 32'h0000_0110};
        vecs[3] = '{32'h2000_0000, 3, 4, 1'b0, 1'b0, 32'h0000_0114};
        vecs[4] = '{32'h1000_8000, 0, 0, 1'b1, 1'b0, 32'hFFFE_0118};
        vecs[5] = '{32'h0BFF_FFFF, 2, 1, 1'b0, 1'b1, 32'hFFFF_FFFC};
        vecs[6] = '{32'h0000_0000, 0, 0, 1'b0, 1'b0, 32'h0000_0000};
        vecs[7] = '{32'h0800_0004, 1, 0, 1'b1, 1'b1, 32'h0000_0010};

        // Zero-wait memory, ready always high.
        reset = 1'b1; instr_ready = 1'b1; pcsrc = 1'b0; jump = 1'b0;
        imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'h0;
        wrap_if.imem_ack = 1'b1; wrap_if.imem_rdata = 32'h0;
        hi_if.imem_ack   = 1'b1; hi_if.imem_rdata   = 32'h0800_0040;
        exp_fetch = 32'h0; exp_stall = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("c0_req", 32'(imem_if.imem_req), 32'd0);
        check("c0_valid", 32'(instr_valid), 32'd0);
        check("c0_pc", pc, 32'h0);
        check("c0_wrap_pc", w_pc, 32'hFFFF_FFFC);
        check("c0_hi_pc", h_pc, 32'h4000_0010);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(posedge clk); @(negedge clk);
            if (cyc % 2 == 1) begin
                check("zw_req", 32'(imem_if.imem_req), 32'd1);
                check("zw_addr", imem_if.imem_addr, 32'(2 * (cyc - 1)));
            end else begin
                check("zw_valid", 32'(instr_valid), 32'd1);
            end
            if (cyc == 1) begin
                check("wrap_addr1", wrap_if.imem_addr, 32'hFFFF_FFFC);
                check("wrap_pp4", w_pp4, 32'h0000_0000);
                check("hi_addr1", hi_if.imem_addr, 32'h4000_0010);
                check("hi_pp4", h_pp4, 32'h4000_0014);
                check("hi_req", 32'(hi_if.imem_req), 32'd1);
            end
            if (cyc == 2) begin
                check("wrap_instr", w_instr, 32'h0);
                check("hi_instr", h_instr, 32'h0800_0040);
                check("side_valid", 32'(w_valid & h_valid), 32'd1);
            end
            if (cyc == 3) begin
                check("wrap_addr2", wrap_if.imem_addr, 32'h0000_0000);
                check("hi_addr2", hi_if.imem_addr, 32'h4000_0100);
`ifdef FETCH_PERF_EN
                check("side_fc", w_fc + h_fc + w_sc + h_sc, 32'd2);
`endif
            end
        end

        // Vector table.
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            txn(vecs[i].rdata, vecs[i].dly, vecs[i].stl, vecs[i].br, vecs[i].jp, vecs[i].nxt);
        end

        // Randomized transactions against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] word;
            logic        br, jp;
            word = $urandom;
            br   = 1'($urandom_range(0, 1));
            jp   = 1'($urandom_range(0, 3) == 0);
            txn(word, $urandom_range(0, 3), $urandom_range(0, 3), br, jp,
                model_next(exp_pc, word, br, jp));
        end

        // Reset while a request is pending, with ack arriving during reset.
        imem_if.imem_ack = 1'b0;
        @(posedge clk); @(negedge clk);
        check("pend_req", 32'(imem_if.imem_req), 32'd1);
        reset = 1'b1; imem_if.imem_ack = 1'b1; imem_if.imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); @(negedge clk);
        reset = 1'b0; imem_if.imem_ack = 1'b0;
        exp_fetch = 32'h0; exp_stall = 32'h0;
        check("rr_valid", 32'(instr_valid), 32'd0);
        check("rr_req", 32'(imem_if.imem_req), 32'd0);
        check("rr_pc", pc, 32'h0);
        check("rr_instr", instr, 32'h0);
        check_perf();
        @(posedge clk); @(negedge clk);
        check("rr_refetch_req", 32'(imem_if.imem_req), 32'd1);
        check("rr_refetch_addr", imem_if.imem_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
